// File: rtl/lit_stream_ctrl.sv
// lit_stream_ctrl
// Frame sequencer that issues source pixels into an external fixed-latency
// LIT datapath, tracks them through a tag pipe and buffers the datapath
// results in a small first-word fall-through FIFO towards the sink.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, frame_len         frame request; frame_len sampled when accepted
//   busy, done               frame in progress / one-cycle end-of-frame pulse
//   s_valid, s_ready, s_data source pixel handshake
//   lit_in                   registered drive into the LIT datapath
//   lit_out                  LIT datapath result
//   m_valid, m_ready,
//   m_data, m_last           sink handshake, m_last on the final pixel
//
// State | meaning
// IDLE  | waiting for start
// RUN   | issuing pixels until len have been accepted
// DRAIN | all pixels issued, waiting for the last beat to leave
module lit_stream_ctrl #(
    parameter int LIT_IN  = 8,
    parameter int LIT_OUT = 16,
    parameter int LAT     = 1,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        frame_len,
    output logic               busy,
    output logic               done,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [LIT_IN-1:0]  s_data,
    output logic [LIT_IN-1:0]  lit_in,
    input  logic [LIT_OUT-1:0] lit_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [LIT_OUT-1:0] m_data,
    output logic               m_last
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

    logic [1:0]         state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        issue_cnt_q, issue_cnt_d;
    logic [LIT_IN-1:0]  lit_in_q, lit_in_d;
    logic [LAT-1:0]     tag_v_q, tag_v_d;
    logic [LAT-1:0]     tag_l_q, tag_l_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               done_q, done_d;

    logic [LIT_OUT-1:0] mem_data_q [DEPTH];
    logic               mem_last_q [DEPTH];

    logic [CW-1:0]      inflight;
    logic               has_credit;
    logic               issue;
    logic               wr_en;
    logic               rd_en;

    // Credits come from registered occupancy only, so a pop this cycle
    // releases its slot for issue on the next cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(tag_v_q[i]);
        end
        has_credit = (count_q + inflight) < CW'(DEPTH);
    end

    assign s_ready = (state_q == RUN) && (issue_cnt_q < len_q) && has_credit;
    assign issue   = s_valid && s_ready;
    assign wr_en   = tag_v_q[LAT-1];
    assign m_valid = (count_q != '0);
    assign rd_en   = m_valid && m_ready;
    // Head is gated so an empty FIFO never shows stale contents.
    assign m_data  = m_valid ? mem_data_q[rd_ptr_q] : '0;
    assign m_last  = m_valid && mem_last_q[rd_ptr_q];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign lit_in  = lit_in_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len != 16'd0) begin
                        len_d       = frame_len;
                        issue_cnt_d = 16'd0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 16'd1;
                    if (issue_cnt_q + 16'd1 == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_en && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag pipe shifts unconditionally; it mirrors the datapath latency.
    always_comb begin
        lit_in_d   = issue ? s_data : lit_in_q;
        tag_v_d    = '0;
        tag_l_d    = '0;
        tag_v_d[0] = issue;
        tag_l_d[0] = issue && (issue_cnt_q == len_q - 16'd1);
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_l_d[i] = tag_l_q[i-1];
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            lit_in_q    <= '0;
            tag_v_q     <= '0;
            tag_l_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            lit_in_q    <= lit_in_d;
            tag_v_q     <= tag_v_d;
            tag_l_q     <= tag_l_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data_q[wr_ptr_q] <= lit_out;
            mem_last_q[wr_ptr_q] <= tag_l_q[LAT-1];
        end
    end

endmodule
